// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Each access runs IDLE -> SERVE -> ACK; addresses are range/alignment
// checked on grant, and per-port grant counters saturate at all-ones.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int unsigned SIZE_BYTES = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [31:0]      wdata0,
  input  logic [31:0]      wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [31:0]      rdata0,
  output logic [31:0]      rdata1,
  output logic [31:0]      mem_address,
  output logic             mem_write,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic [31:0] SIZE_W = 32'(SIZE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        grant;
  logic        grant_port;
  logic        last_served;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_offset;
  logic        sel_ok;

  logic        port_lat;
  logic        we_lat;
  logic        ok_lat;
  logic [31:0] rd_val;

  // State register; reset drops any access in flight.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and round-robin grant decision; requests only sampled in IDLE.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant      = 1'b1;
          grant_port = ~last_served;
        end else if (req0) begin
          grant      = 1'b1;
          grant_port = 1'b0;
        end else if (req1) begin
          grant      = 1'b1;
          grant_port = 1'b1;
        end
        if (grant) begin
          state_nxt = SERVE;
        end
      end
      SERVE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mux the granted port's request and check range/alignment in unsigned 32-bit.
  always_comb begin
    sel_we     = grant_port ? we1    : we0;
    sel_addr   = grant_port ? addr1  : addr0;
    sel_wdata  = grant_port ? wdata1 : wdata0;
    sel_offset = sel_addr - BASE_ADDR;
    sel_ok     = (sel_addr >= BASE_ADDR) && (sel_offset < SIZE_W) &&
                 (sel_addr[1:0] == 2'b00);
  end

  // Load data captured at the end of SERVE; stores and errors return zero.
  always_comb begin
    rd_val = (!we_lat && ok_lat) ? mem_read_data : '0;
  end

  // Request latch, per-port read data, last-served pointer and grant counters.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      port_lat       <= 1'b0;
      we_lat         <= 1'b0;
      ok_lat         <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      rdata0         <= '0;
      rdata1         <= '0;
      last_served    <= 1'b1;
      gnt_cnt0       <= '0;
      gnt_cnt1       <= '0;
    end else begin
      if (grant) begin
        port_lat       <= grant_port;
        we_lat         <= sel_we;
        ok_lat         <= sel_ok;
        mem_address    <= sel_addr;
        mem_write_data <= sel_wdata;
      end
      if (state == SERVE) begin
        if (port_lat) begin
          rdata1 <= rd_val;
        end else begin
          rdata0 <= rd_val;
        end
      end
      if (state == ACK) begin
        last_served <= port_lat;
        if (!port_lat && (gnt_cnt0 != '1)) begin
          gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
        end
        if (port_lat && (gnt_cnt1 != '1)) begin
          gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
      end
    end
  end

  // Completion strobes and the memory write enable decode straight from state.
  always_comb begin
    mem_write = (state == SERVE) && we_lat && ok_lat;
    ack0      = (state == ACK) && !port_lat;
    ack1      = (state == ACK) &&  port_lat;
    err0      = ack0 && !ok_lat;
    err1      = ack1 && !ok_lat;
  end

endmodule
